mole_host_link: RTL and testbench
=================================

// Module: mole_host_link
// PURPOSE
//  Host-end UART protocol engine for the whack-a-mole link; the counterpart of the game board's UART port.
//  Deserialises the game's mole-position bytes ({3'b000, mole[4:0]}) and drives its LEDs/state.
//  Serialises player commands back to the game: ASCII 'S' (0x53) = start, 'H' (0x48) = valid hit.
//  Lets a second board (remote player) or the simulation bench act as the PC side.
// PARAMETERS
//  CLKS_PER_BIT  10417  clock cycles per UART bit (100 MHz / 9600 baud); legal range >= 4
// PORTS
//  clock           in   1  system clock (100 MHz)
//  reset           in   1  asynchronous, active-low reset
//  uart_rx_pin     in   1  serial in from the game's TX pin (asynchronous, idle high)
//  uart_tx_pin     out  1  serial out to the game's RX pin (idle high)
//  start_req       in   1  one-cycle pulse (debounced start button) -> send 'S'
//  hit_btn         in   5  one-cycle pulses (debounced mole buttons)
//  mole_position   out  5  last accepted mole byte[4:0]; drives remote LEDs
//  mole_update     out  1  one-cycle pulse when mole_position is written
//  frame_error     out  1  one-cycle pulse: stop bit sampled low
//  proto_error     out  1  one-cycle pulse: byte well-framed but not a legal mole code
//  tx_busy         out  1  high while a command frame is on the line
// BEHAVIOUR
//  Reset: uart_tx_pin=1, tx_busy=0, mole_position=0, all pulse outputs=0; both FSMs IDLE; pending flags cleared; hit_armed=0.
//  Reset asserted mid-frame: the line returns high immediately; the partial frame is abandoned, no pulses are emitted.
//  RX:
//   - 2-FF synchroniser on uart_rx_pin.
//   - FSM: R_IDLE -> R_START (falling edge seen; wait CLKS_PER_BIT/2).
//   - R_START: if the line is still low -> R_DATA, else glitch -> R_IDLE.
//   - R_DATA: 8 samples at CLKS_PER_BIT spacing, LSB first.
//   - R_STOP: sample once. Low -> frame_error, byte discarded. High -> byte checked.
//  Legal mole code: byte[7:5]==0 and popcount(byte[4:0])<=1.
//   - Legal: mole_position<=byte[4:0], mole_update pulses one cycle after the stop sample, hit_armed<=(byte[4:0]!=0).
//   - Illegal: proto_error pulses; mole_position unchanged.
//  Hit qualification:
//   - Condition: hit_armed && |(hit_btn & mole_position) -> hit_pend<=1, hit_armed<=0. This allows one 'H' per mole appearance.
//   - Wrong button or hit_armed=0: ignored.
//   - If mole_update and a qualifying hit occur in the same cycle: the hit is judged against the old mole_position, and the re-arm from the update wins.
//  Start: start_req -> start_pend<=1. Further requests while pending are merged; no queue depth beyond 1 per command.
//  TX:
//   - FSM: T_IDLE -> T_START -> T_DATA (8 bits, LSB first) -> T_STOP -> T_IDLE. Each state lasts CLKS_PER_BIT cycles.
//   - Frame length: 10*CLKS_PER_BIT cycles.
//   - In T_IDLE: start_pend has priority over hit_pend. The chosen pend flag clears when the frame is loaded.
//   - Latency: tx_busy rises and the line goes low one cycle after loading.
//   - tx_busy stays high until the end of T_STOP. Back-to-back frames are allowed, with no extra idle bit.
//   - Pend flags set during a frame are held and sent afterwards.
//  Counters: bit counter 0..7; baud counter 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary.
// CONFIGURATION
//  `MOLE_LINK_STATS_EN defined:
//   - Adds output hit_count[7:0]: +1 per 'H' frame loaded, saturating at 255, 0 at reset.
//   - Adds output err_count[7:0]: +1 per frame_error or proto_error, saturating at 255, 0 at reset.
//  `MOLE_LINK_STATS_EN not defined: neither port nor the counters exist; all other behaviour is identical.
// STRUCTURE
//  Package mole_link_pkg:
//   - CMD_START=8'h53, CMD_HIT=8'h48, MOLE_NONE=5'b00000
//   - rx_state_t {R_IDLE,R_START,R_DATA,R_STOP}
//   - tx_state_t {T_IDLE,T_START,T_DATA,T_STOP}
//   - is_legal_mole() function
//  Sub-module uart_rx_core (synchroniser, RX FSM, byte + valid + frame_err pulses).
//  TX FSM, arbitration and hit logic stay inline.
// TESTING (bench uses CLKS_PER_BIT=16)
//  1. Drive 8N1 byte 0x04 on uart_rx_pin -> mole_position=5'b00100, one mole_update pulse, no errors.
//  2. After 1, pulse hit_btn=5'b00100 -> uart_tx_pin emits 0x48 (160 cycles, tx_busy high throughout).
//     A second pulse on the same mole sends nothing.
//  3. After 1, pulse hit_btn=5'b00001 -> no frame, tx_busy stays 0.
//  4. start_req and a qualifying hit in the same cycle -> frames 0x53 then 0x48 back-to-back (320 cycles busy).
//  5. RX byte 0x06 -> proto_error pulse, mole_position holds. Frame 0x02 with stop bit 0 -> frame_error pulse, no update.
//  6. Assert reset mid-TX (bit 4 of 'S') -> uart_tx_pin=1 and tx_busy=0 immediately; no frame after release until a new request.

Source files
------------

// File: rtl/mole_link_pkg.sv
// Shared definitions for the whack-a-mole host link.
// Contents: command byte codes, the "no mole" code, the RX and TX state
// types, and is_legal_mole(), which accepts a byte only when its top three
// bits are zero and at most one mole bit is set.
package mole_link_pkg;

    localparam logic [7:0] CMD_START = 8'h53;
    localparam logic [7:0] CMD_HIT   = 8'h48;
    localparam logic [4:0] MOLE_NONE = 5'b00000;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    // At most one mole bit set: clearing the lowest set bit must leave zero.
    function automatic logic is_legal_mole(input logic [7:0] b);
        return (b[7:5] == 3'b000) && ((b[4:0] & (b[4:0] - 5'd1)) == 5'd0);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, start-bit validation at mid-bit,
// 8 LSB-first data samples, single stop-bit sample.
// Ports:
//   clock, reset    system clock, async active-low reset
//   rx_pin          asynchronous serial input, idle high
//   rx_byte[7:0]    last received byte (valid when rx_valid pulses)
//   rx_valid        one-cycle pulse: stop bit high, rx_byte is good
//   rx_ferr         one-cycle pulse: stop bit sampled low, byte dropped
//
// state   | meaning
// R_IDLE  | line high, waiting for a low level
// R_START | half-bit wait, then confirm the start bit is still low
// R_DATA  | sampling 8 data bits, one per bit period
// R_STOP  | sampling the stop bit
module uart_rx_core
    import mole_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_pin,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync_a, sync_b;
    rx_state_t     state, state_n;
    logic [CW-1:0] baud, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    data_n;
    logic          valid_n, ferr_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a   <= 1'b1;
            sync_b   <= 1'b1;
            state    <= R_IDLE;
            baud     <= '0;
            bit_cnt  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            sync_a   <= rx_pin;
            sync_b   <= sync_a;
            state    <= state_n;
            baud     <= baud_n;
            bit_cnt  <= bit_n;
            rx_byte  <= data_n;
            rx_valid <= valid_n;
            rx_ferr  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_cnt;
        data_n  = rx_byte;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            R_IDLE: begin
                baud_n = '0;
                if (!sync_b) state_n = R_START;
            end
            R_START: begin
                if (baud == BAUD_HALF) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = sync_b ? R_IDLE : R_DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            R_DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    data_n = {sync_b, rx_byte[7:1]};
                    if (bit_cnt == 3'd7) state_n = R_STOP;
                    else                 bit_n   = bit_cnt + 1'b1;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            R_STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = R_IDLE;
                    valid_n = sync_b;
                    ferr_n  = !sync_b;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: state_n = R_IDLE;
        endcase
    end

endmodule

// File: rtl/mole_host_link.sv
// Host-end protocol engine for the whack-a-mole UART link.
// Receives mole-position bytes, validates them, tracks the current mole,
// qualifies hit buttons (one 'H' per mole appearance) and serialises the
// 'S'/'H' command bytes back to the game board.
// Optional feature: define MOLE_LINK_STATS_EN to add hit_count/err_count.
// Ports:
//   clock, reset        system clock, async active-low reset
//   uart_rx_pin         serial in from the game (idle high)
//   uart_tx_pin         serial out to the game (idle high)
//   start_req           one-cycle start request -> 'S'
//   hit_btn[4:0]        one-cycle mole button pulses
//   mole_position[4:0]  last accepted mole code
//   mole_update         pulse when mole_position is written
//   frame_error         pulse: stop bit low
//   proto_error         pulse: well-framed byte that is not a mole code
//   tx_busy             high while a command frame is on the line
//   hit_count, err_count  (MOLE_LINK_STATS_EN only) saturating counters
//
// state   | meaning
// T_IDLE  | line high; load 'S' (priority) or 'H' when pending
// T_START | start bit
// T_DATA  | 8 data bits, LSB first
// T_STOP  | stop bit; may chain straight into the next frame
module mole_host_link
    import mole_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx_pin,
    output logic       uart_tx_pin,
    input  logic       start_req,
    input  logic [4:0] hit_btn,
    output logic [4:0] mole_position,
    output logic       mole_update,
    output logic       frame_error,
    output logic       proto_error,
`ifdef MOLE_LINK_STATS_EN
    output logic [7:0] hit_count,
    output logic [7:0] err_count,
`endif
    output logic       tx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_legal;
    logic       hit_armed, hit_pend, start_pend, hit_qual;

    tx_state_t     state, state_n;
    logic [CW-1:0] baud, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shreg, sh_n;
    logic          line_n, busy_n, take_s, take_h;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock    (clock),
        .reset    (reset),
        .rx_pin   (uart_rx_pin),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ferr  (frame_error)
    );

    assign rx_legal = is_legal_mole(rx_byte);
    // Judged against the current (old) mole_position even when an update lands.
    assign hit_qual = hit_armed && |(hit_btn & mole_position);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mole_position <= MOLE_NONE;
            mole_update   <= 1'b0;
            proto_error   <= 1'b0;
            hit_armed     <= 1'b0;
            hit_pend      <= 1'b0;
            start_pend    <= 1'b0;
        end else begin
            mole_update <= 1'b0;
            proto_error <= 1'b0;
            if (take_h)   hit_pend <= 1'b0;
            if (hit_qual) begin
                hit_pend  <= 1'b1;
                hit_armed <= 1'b0;
            end
            if (rx_valid) begin
                if (rx_legal) begin
                    mole_position <= rx_byte[4:0];
                    mole_update   <= 1'b1;
                    hit_armed     <= |rx_byte[4:0];  // overrides the disarm above
                end else begin
                    proto_error <= 1'b1;
                end
            end
            // A request arriving while 'S' is still pending merges into it.
            if (take_s)         start_pend <= 1'b0;
            else if (start_req) start_pend <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= T_IDLE;
            baud        <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            uart_tx_pin <= 1'b1;
            tx_busy     <= 1'b0;
        end else begin
            state       <= state_n;
            baud        <= baud_n;
            bit_cnt     <= bit_n;
            shreg       <= sh_n;
            uart_tx_pin <= line_n;
            tx_busy     <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        line_n  = uart_tx_pin;
        busy_n  = tx_busy;
        take_s  = 1'b0;
        take_h  = 1'b0;
        case (state)
            T_IDLE: begin
                line_n = 1'b1;
                busy_n = 1'b0;
                baud_n = '0;
                if (start_pend || hit_pend) begin
                    take_s  = start_pend;
                    take_h  = !start_pend;
                    sh_n    = start_pend ? CMD_START : CMD_HIT;
                    state_n = T_START;
                    line_n  = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            T_START: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = T_DATA;
                    line_n  = shreg[0];
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            T_DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
                        state_n = T_STOP;
                        line_n  = 1'b1;
                    end else begin
                        bit_n  = bit_cnt + 1'b1;
                        sh_n   = {1'b0, shreg[7:1]};
                        line_n = shreg[1];
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            T_STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    // Chain directly into the next frame with no idle bit.
                    if (start_pend || hit_pend) begin
                        take_s  = start_pend;
                        take_h  = !start_pend;
                        sh_n    = start_pend ? CMD_START : CMD_HIT;
                        state_n = T_START;
                        line_n  = 1'b0;
                    end else begin
                        state_n = T_IDLE;
                        line_n  = 1'b1;
                        busy_n  = 1'b0;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: state_n = T_IDLE;
        endcase
    end

`ifdef MOLE_LINK_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count <= '0;
            err_count <= '0;
        end else begin
            if (take_h && hit_count != 8'hFF)                     hit_count <= hit_count + 1'b1;
            if ((frame_error || proto_error) && err_count != 8'hFF) err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mole_host_link.sv
// Directed bench for mole_host_link with CLKS_PER_BIT=16.
module tb_mole_host_link;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx_pin = 1'b1;
    logic       uart_tx_pin;
    logic       start_req = 1'b0;
    logic [4:0] hit_btn = 5'd0;
    logic [4:0] mole_position;
    logic       mole_update, frame_error, proto_error, tx_busy;
`ifdef MOLE_LINK_STATS_EN
    logic [7:0] hit_count, err_count;
`endif

    int tests = 0;
    int fails = 0;

    int upd_cnt = 0, perr_cnt = 0, ferr_cnt = 0, busy_cyc = 0;
    int run = 0, last_run = 0;

    always #5 clock = ~clock;

    mole_host_link #(.CLKS_PER_BIT(CPB)) dut (
        .clock         (clock),
        .reset         (reset),
        .uart_rx_pin   (uart_rx_pin),
        .uart_tx_pin   (uart_tx_pin),
        .start_req     (start_req),
        .hit_btn       (hit_btn),
        .mole_position (mole_position),
        .mole_update   (mole_update),
        .frame_error   (frame_error),
        .proto_error   (proto_error),
`ifdef MOLE_LINK_STATS_EN
        .hit_count     (hit_count),
        .err_count     (err_count),
`endif
        .tx_busy       (tx_busy)
    );

    always @(posedge clock) begin
        if (mole_update) upd_cnt  <= upd_cnt + 1;
        if (proto_error) perr_cnt <= perr_cnt + 1;
        if (frame_error) ferr_cnt <= ferr_cnt + 1;
        if (tx_busy) begin
            busy_cyc <= busy_cyc + 1;
            run      <= run + 1;
        end else if (run != 0) begin
            last_run <= run;
            run      <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clock); uart_rx_pin = 1'b0;
        repeat (CPB) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx_pin = b[i];
            repeat (CPB) @(posedge clock);
        end
        uart_rx_pin = stop;
        repeat (CPB) @(posedge clock);
        uart_rx_pin = 1'b1;
        repeat (CPB) @(posedge clock);
    endtask

    task automatic pulse_inputs(input logic s, input logic [4:0] h);
        @(negedge clock); start_req = s; hit_btn = h;
        @(negedge clock); start_req = 1'b0; hit_btn = 5'd0;
    endtask

    task automatic wait_tx_low(output logic found);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clock);
            if (uart_tx_pin == 1'b0) found = 1'b1;
        end
    endtask

    task automatic capture_frame(input string tag, input logic [7:0] exp);
        logic found;
        logic [7:0] b;
        logic st, sp;
        b = 8'h00;
        wait_tx_low(found);
        check({tag, "_start_seen"}, {31'd0, found}, 32'd1);
        repeat (CPB / 2) @(negedge clock);
        st = uart_tx_pin;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clock);
            b[i] = uart_tx_pin;
        end
        repeat (CPB) @(negedge clock);
        sp = uart_tx_pin;
        check({tag, "_startbit"}, {31'd0, st}, 32'd0);
        check({tag, "_byte"}, {24'd0, b}, {24'd0, exp});
        check({tag, "_stopbit"}, {31'd0, sp}, 32'd1);
    endtask

    int u0, p0, f0, b0;
    logic found;

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_tx_pin", {31'd0, uart_tx_pin}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_mole", {27'd0, mole_position}, 32'd0);
        check("rst_pulses", {29'd0, mole_update, frame_error, proto_error}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // 1: legal mole byte 0x04
        u0 = upd_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_byte(8'h04, 1'b1);
        repeat (4) @(negedge clock);
        check("t1_mole", {27'd0, mole_position}, 32'd4);
        check("t1_upd", upd_cnt - u0, 32'd1);
        check("t1_errs", (perr_cnt - p0) + (ferr_cnt - f0), 32'd0);

        // 2: qualifying hit -> 'H', 160 busy cycles; second hit ignored
        pulse_inputs(1'b0, 5'b00100);
        capture_frame("t2_h", 8'h48);
        repeat (CPB) @(negedge clock);
        check("t2_busy_len", last_run, 32'd160);
        b0 = busy_cyc;
        pulse_inputs(1'b0, 5'b00100);
        repeat (200) @(negedge clock);
        check("t2_no_rehit", busy_cyc - b0, 32'd0);

        // 3: re-arm, wrong button ignored
        send_byte(8'h04, 1'b1);
        repeat (4) @(negedge clock);
        b0 = busy_cyc;
        pulse_inputs(1'b0, 5'b00001);
        repeat (200) @(negedge clock);
        check("t3_wrong_btn", busy_cyc - b0, 32'd0);
        check("t3_line_idle", {31'd0, uart_tx_pin}, 32'd1);

        // 4: start + hit together -> 'S' then 'H' back-to-back
        pulse_inputs(1'b1, 5'b00100);
        capture_frame("t4_s", 8'h53);
        capture_frame("t4_h", 8'h48);
        repeat (CPB) @(negedge clock);
        check("t4_busy_len", last_run, 32'd320);

        // 5: illegal code, then framing error
        u0 = upd_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_byte(8'h06, 1'b1);
        repeat (4) @(negedge clock);
        check("t5_perr", perr_cnt - p0, 32'd1);
        check("t5_mole_hold", {27'd0, mole_position}, 32'd4);
        send_byte(8'h02, 1'b0);
        repeat (4) @(negedge clock);
        check("t5_ferr", ferr_cnt - f0, 32'd1);
        check("t5_no_upd", upd_cnt - u0, 32'd0);
        check("t5_mole_hold2", {27'd0, mole_position}, 32'd4);

        // Boundary: top mole bit and the empty code are both legal
        send_byte(8'h10, 1'b1);
        repeat (4) @(negedge clock);
        check("b_mole_10", {27'd0, mole_position}, 32'd16);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clock);
        check("b_mole_00", {27'd0, mole_position}, 32'd0);
        check("b_upd2", upd_cnt - u0, 32'd2);

        // 6: reset in the middle of bit 4 of 'S'
        pulse_inputs(1'b1, 5'd0);
        wait_tx_low(found);
        check("t6_start_seen", {31'd0, found}, 32'd1);
        repeat (CPB * 5 + CPB / 2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("t6_rst_line", {31'd0, uart_tx_pin}, 32'd1);
        check("t6_rst_busy", {31'd0, tx_busy}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        b0 = busy_cyc;
        repeat (200) @(negedge clock);
        check("t6_no_resume", busy_cyc - b0, 32'd0);
        check("t6_line_idle", {31'd0, uart_tx_pin}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
